// File: rtl/skew_stage.sv
// Per-lane skew/deskew delay lines for the systolic-array datapath, with runtime
// mode select, global stall, synchronous flush, drain tracking and misalignment flag.
module skew_stage #(
   parameter int LANES      = 8,
   parameter int DATA_W     = 32,
   parameter int BASE_DELAY = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode_deskew,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic [LANES-1:0]        in_valid,
   input  logic                    stall,
   input  logic                    flush,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [LANES-1:0]        out_valid,
   output logic                    busy,
   output logic                    mode_q,
   output logic                    err_misalign
);

   localparam int DEPTH = BASE_DELAY + LANES - 1;

   typedef enum logic {
      MODE_SKEW   = 1'b0,
      MODE_DESKEW = 1'b1
   } mode_e;

   logic [LANES-1:0] lane_busy;
   logic [LANES-1:0] tap_valid;
   logic             advance;
   logic             misaligned;

   // Data moves only on edges that are neither stalled nor flushed.
   assign advance = !stall && !flush;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int D_SKEW   = BASE_DELAY + i;
      localparam int D_DESKEW = BASE_DELAY + (LANES - 1 - i);
      localparam int LEN      = (D_SKEW > D_DESKEW) ? D_SKEW : D_DESKEW;

      // Valid bits span the full depth so busy tracks a beat for DEPTH cycles on
      // every lane; data only needs to reach the furthest tap this lane can use.
      logic [DEPTH:1]    vld_q;
      logic [DATA_W-1:0] dat_q [1:LEN];

      // NOTE: every register in this design is written with <=, so each stage
      // samples its neighbour's pre-edge value and the chain shifts by exactly one.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= '0;
         end else if (flush) begin
            vld_q <= '0;
         end else if (!stall) begin
            vld_q <= (vld_q << 1) | DEPTH'(in_valid[i]);
         end
      end

      // NOTE: the data stages are reset as well (not just the valids), because
      // out_data must read 0 straight out of reset.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 1; k <= LEN; k++) begin
               dat_q[k] <= '0;
            end
         end else if (advance) begin
            dat_q[1] <= in_data[i*DATA_W +: DATA_W];
            for (int k = 2; k <= LEN; k++) begin
               dat_q[k] <= dat_q[k-1];
            end
         end
      end

      assign tap_valid[i] = (mode_q == MODE_DESKEW) ? vld_q[D_DESKEW] : vld_q[D_SKEW];
      assign out_data[i*DATA_W +: DATA_W] =
         (mode_q == MODE_DESKEW) ? dat_q[D_DESKEW] : dat_q[D_SKEW];
      assign lane_busy[i] = |vld_q;
   end

   assign out_valid = tap_valid & ~{LANES{stall}};
   assign busy      = |lane_busy;

   // A mode request is only honoured once the pipe is empty and no beat is arriving.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_SKEW;
      end else if (!busy && (in_valid == '0)) begin
         mode_q <= mode_deskew;
      end
   end

   assign misaligned = (mode_q == MODE_DESKEW) && !stall &&
                       (out_valid != '0) && (out_valid != '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_misalign <= 1'b0;
      end else if (flush) begin
         err_misalign <= 1'b0;
      end else if (misaligned) begin
         err_misalign <= 1'b1;
      end
   end

endmodule
